// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   op_e     : 3-bit operation encoding driven on muldiv_unit.op
//   state_e  : FSM state encoding, also visible on muldiv_unit.dbg_state
//   is_div   : op is one of DIV, DIVU, REM, REMU
//   is_rem   : op returns the remainder (REM, REMU)
//   a_signed : operand a is treated as two's complement for this op
//   b_signed : operand b is treated as two's complement for this op
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// cond_negate -- conditional two's-complement negation.
//   x   : input value (W bits)
//   neg : 1 = output -x, 0 = output x unchanged
//   y   : result (W bits, wraps modulo 2**W)
module cond_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative radix-2 multiply / divide unit.
//   clk       : clock, rising edge
//   rstn      : asynchronous active-low reset
//   start     : request strobe, accepted only on an edge where ready=1
//   op        : operation (see muldiv_pkg::op_e)
//   a, b      : operands (multiplicand/dividend, multiplier/divisor)
//   kill      : synchronous abort; returns to IDLE without a done pulse
//   ready     : unit idle, a start on this cycle's edge is accepted
//   done      : one-cycle pulse, result valid in that cycle
//   result    : last completed result, held until the next done
//   dbg_state : current FSM state (muldiv_pkg::state_e encoding)
//
// Handshake: a request transfers on a rising edge where start=1, ready=1 and
// kill=0; op/a/b are captured on that edge only. start while ready=0 is
// dropped (no queue). done and ready are never high together; ready rises
// the cycle after done, and a start in that cycle is accepted.
//
// Flow: IDLE -> CALC (N iterations on operand magnitudes) -> FIX (sign
// correction) -> DONE -> IDLE. Divide-by-zero and the signed DIV/REM
// overflow case skip straight from IDLE to DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         kill,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] result,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(N) + 1;

    state_e         state;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;     // multiply: {partial hi, multiplier}; divide: {remainder, quotient}
    logic [N-1:0]   opnd;    // multiplicand or divisor magnitude
    logic           neg_q;   // final result must be negated in FIX
    logic [2:0]     op_q;

    // ---------------- operand decode at request time ----------------
    logic         a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;
    logic         b_zero, sdiv_ovf, req_neg;

    assign a_neg = a_signed(op) & a[N-1];
    assign b_neg = b_signed(op) & b[N-1];

    cond_negate #(.W(N)) u_abs_a (.x(a), .neg(a_neg), .y(a_mag));
    cond_negate #(.W(N)) u_abs_b (.x(b), .neg(b_neg), .y(b_mag));

    assign b_zero   = (b == '0);
    assign sdiv_ovf = is_div(op) & a_signed(op)
                    & (a == {1'b1, {(N-1){1'b0}}}) & (b == '1);
    // Remainder follows the dividend sign; everything else is sign(a)^sign(b).
    assign req_neg  = is_rem(op) ? a_neg : (a_neg ^ b_neg);

    // ---------------- one radix-2 step ----------------
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;
    logic [N:0]     div_diff;
    logic [2*N-1:0] div_next;

    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole accumulator right with the carry.
    assign mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, opnd};
    assign mul_next = acc[0] ? {mul_sum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};

    // Restoring divide: shift {rem, quo} left, trial-subtract the divisor
    // from the N+1-bit partial remainder; a borrow (bit N) means restore.
    assign div_diff = {acc[2*N-1:N], acc[N-1]} - {1'b0, opnd};
    assign div_next = div_diff[N] ? {acc[2*N-2:0], 1'b0}
                                  : {div_diff[N-1:0], acc[N-2:0], 1'b1};

    // ---------------- sign fix-up ----------------
    logic [2*N-1:0] fix_src, fix_res;
    logic [N-1:0]   fix_out;

    assign fix_src = is_rem(op_q) ? {{N{1'b0}}, acc[2*N-1:N]} :
                     is_div(op_q) ? {{N{1'b0}}, acc[N-1:0]}   : acc;

    cond_negate #(.W(2*N)) u_fix (.x(fix_src), .neg(neg_q), .y(fix_res));

    assign fix_out = (is_div(op_q) || op_q == OP_MUL) ? fix_res[N-1:0]
                                                      : fix_res[2*N-1:N];

    assign dbg_state = state;

    // ---------------- FSM and datapath registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            op_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // kill has priority: a simultaneous request is dropped.
                    if (start && !kill) begin
                        op_q  <= op;
                        neg_q <= req_neg;
                        ready <= 1'b0;
                        if (is_div(op) && b_zero) begin
                            result <= is_rem(op) ? a : '1;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else if (sdiv_ovf) begin
                            result <= is_rem(op) ? '0 : a;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            acc   <= {{N{1'b0}}, (is_div(op) ? a_mag : b_mag)};
                            opnd  <= is_div(op) ? b_mag : a_mag;
                            cnt   <= CW'(N - 1);
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (kill) begin
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        acc <= is_div(op_q) ? div_next : mul_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (kill) begin
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        result <= fix_out;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit (N=32).
// Expected results come from a plain-arithmetic model (64-bit integer
// multiply/divide); expected latency comes from the cycle-count rules.
module tb_muldiv_unit;

    localparam int N = 32;
    localparam int LAT_BUDGET = 3 * N;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic         kill;
    logic         ready, done;
    logic [N-1:0] result;
    logic [1:0]   dbg_state;

    int tests_run;
    int tests_failed;

    logic [N-1:0] exp_q[$];

    muldiv_unit #(.N(N)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
        .kill(kill), .ready(ready), .done(done), .result(result),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] model(input logic [2:0] o, input logic [N-1:0] x,
                                          input logic [N-1:0] y);
        longint          sx, sy, sq;
        longint unsigned ux, uy, uq;
        logic [63:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = '0;
        case (o)
            3'd0: begin uq = ux * uy;           r = uq;        end
            3'd1: begin sq = sx * sy;           r = sq >>> 32; end
            3'd2: begin sq = sx * longint'(uy); r = sq >>> 32; end
            3'd3: begin uq = ux * uy;           r = uq >> 32;  end
            3'd4: r = (y == 0) ? 64'hFFFF_FFFF : 64'(sx / sy);
            3'd5: r = (y == 0) ? 64'hFFFF_FFFF : 64'(ux / uy);
            3'd6: r = (y == 0) ? {32'd0, x}    : 64'(sx % sy);
            default: r = (y == 0) ? {32'd0, x} : 64'(ux % uy);
        endcase
        return r[N-1:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [N-1:0] x,
                                   input logic [N-1:0] y);
        if (o >= 3'd4 && y == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return N + 2;
    endfunction

    // ---------------- driver tasks ----------------
    // Presents a request before the next rising edge (cycle 0), then scrambles
    // the inputs so any late sampling of op/a/b corrupts the result.
    task automatic issue(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom_range(0, 7));
        a  = $urandom;
        b  = $urandom;
    endtask

    // Counts cycles from 1 after issue; lat=0 means the budget expired.
    task automatic wait_done(output int lat, output logic [N-1:0] res,
                             output logic both_hi, output logic rdy_next,
                             output logic done_next);
        lat = 0; res = '0; both_hi = 1'b0; rdy_next = 1'b0; done_next = 1'b0;
        for (int k = 1; k <= LAT_BUDGET && lat == 0; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k; res = result; both_hi = ready;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            rdy_next  = ready;
            done_next = done;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", ready); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++;
        if (result !== '0) begin tests_failed++; $display("FAIL reset_result got %h want 0", result); end
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_hold ready=%b done=%b want 1/0", ready, done);
        end
        start = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]   vo[14];
        logic [N-1:0] va[14], vb[14], ve[14];
        int           vl[14];
        int           lat;
        logic [N-1:0] res;
        logic         both, rdy, dn;
        vo[0]  = 3'd0; va[0]  = 32'd7;         vb[0]  = 32'hFFFF_FFFD; ve[0]  = 32'hFFFF_FFEB; vl[0]  = 34;
        vo[1]  = 3'd1; va[1]  = 32'h8000_0000; vb[1]  = 32'h8000_0000; ve[1]  = 32'h4000_0000; vl[1]  = 34;
        vo[2]  = 3'd3; va[2]  = 32'hFFFF_FFFF; vb[2]  = 32'hFFFF_FFFF; ve[2]  = 32'hFFFF_FFFE; vl[2]  = 34;
        vo[3]  = 3'd2; va[3]  = 32'hFFFF_FFFF; vb[3]  = 32'd2;         ve[3]  = 32'hFFFF_FFFF; vl[3]  = 34;
        vo[4]  = 3'd4; va[4]  = 32'hFFFF_FFF9; vb[4]  = 32'd2;         ve[4]  = 32'hFFFF_FFFD; vl[4]  = 34;
        vo[5]  = 3'd6; va[5]  = 32'hFFFF_FFF9; vb[5]  = 32'd2;         ve[5]  = 32'hFFFF_FFFF; vl[5]  = 34;
        vo[6]  = 3'd5; va[6]  = 32'd100;       vb[6]  = 32'd7;         ve[6]  = 32'd14;        vl[6]  = 34;
        vo[7]  = 3'd7; va[7]  = 32'd100;       vb[7]  = 32'd7;         ve[7]  = 32'd2;         vl[7]  = 34;
        vo[8]  = 3'd5; va[8]  = 32'd5;         vb[8]  = 32'd0;         ve[8]  = 32'hFFFF_FFFF; vl[8]  = 1;
        vo[9]  = 3'd6; va[9]  = 32'd5;         vb[9]  = 32'd0;         ve[9]  = 32'd5;         vl[9]  = 1;
        vo[10] = 3'd4; va[10] = 32'h8000_0000; vb[10] = 32'hFFFF_FFFF; ve[10] = 32'h8000_0000; vl[10] = 1;
        vo[11] = 3'd6; va[11] = 32'h8000_0000; vb[11] = 32'hFFFF_FFFF; ve[11] = 32'd0;         vl[11] = 1;
        vo[12] = 3'd4; va[12] = 32'hFFFF_FFF0; vb[12] = 32'd0;         ve[12] = 32'hFFFF_FFFF; vl[12] = 1;
        vo[13] = 3'd7; va[13] = 32'd9;         vb[13] = 32'd0;         ve[13] = 32'd9;         vl[13] = 1;
        for (int i = 0; i < 14; i++) begin
            issue(vo[i], va[i], vb[i]);
            wait_done(lat, res, both, rdy, dn);
            tests_run++;
            if (res !== ve[i]) begin
                tests_failed++; $display("FAIL directed_%0d_result got %h want %h", i, res, ve[i]);
            end
            tests_run++;
            if (lat != vl[i]) begin
                tests_failed++; $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, vl[i]);
            end
            tests_run++;
            if (both !== 1'b0 || rdy !== 1'b1 || dn !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_%0d_handshake ready@done=%b ready_next=%b done_next=%b want 0/1/0",
                         i, both, rdy, dn);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]   o;
        logic [N-1:0] x, y, exp;
        int           lat, el;
        logic [N-1:0] res;
        logic         both, rdy, dn;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: begin x = $urandom; y = $urandom; end
                1: begin x = $urandom_range(0, 20); y = $urandom_range(0, 20); end
                2: begin x = $urandom; y = '0; end
                3: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                4: begin x = $urandom; y = 32'($signed(6'($urandom_range(0, 63)))); end
                default: begin x = 32'h8000_0000; y = $urandom; end
            endcase
            exp_q.push_back(model(o, x, y));
            el = exp_lat(o, x, y);
            issue(o, x, y);
            wait_done(lat, res, both, rdy, dn);
            exp = exp_q.pop_front();
            tests_run++;
            if (res !== exp) begin
                tests_failed++; $display("FAIL random_%0d_result op=%0d a=%h b=%h got %h want %h",
                                         i, o, x, y, res, exp);
            end
            tests_run++;
            if (lat != el) begin
                tests_failed++; $display("FAIL random_%0d_latency got %0d want %0d", i, lat, el);
            end
            tests_run++;
            if (both !== 1'b0 || rdy !== 1'b1 || dn !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_%0d_handshake ready@done=%b ready_next=%b done_next=%b want 0/1/0",
                         i, both, rdy, dn);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // Each new request is presented in the very cycle ready rises.
    task automatic test_back_to_back();
        logic [2:0]   o;
        logic [N-1:0] x, y, exp;
        int           lat, el;
        logic [N-1:0] res;
        logic         both, rdy, dn;
        for (int i = 0; i < 6; i++) begin
            o = (i == 3) ? 3'd5 : 3'($urandom_range(0, 7));
            x = $urandom;
            y = (i == 3) ? '0 : $urandom;
            exp_q.push_back(model(o, x, y));
            el = exp_lat(o, x, y);
            issue(o, x, y);
            wait_done(lat, res, both, rdy, dn);
            exp = exp_q.pop_front();
            tests_run++;
            if (res !== exp || lat != el || rdy !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_%0d result=%h lat=%0d ready_next=%b want %h/%0d/1",
                         i, res, lat, rdy, exp, el);
            end
        end
    endtask

    task automatic test_start_ignored();
        int           lat, n;
        logic [N-1:0] res;
        lat = 0; res = '0;
        issue(3'd5, 32'd1000, 32'd3);
        for (int k = 1; k <= LAT_BUDGET && lat == 0; k++) begin
            @(negedge clk);
            if (done) begin lat = k; res = result; end
            if (k == 5) begin start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; end
            if (k == 6) start = 1'b0;
        end
        tests_run++;
        if (res !== 32'd333 || lat != N + 2) begin
            tests_failed++; $display("FAIL start_ignored result=%h lat=%0d want 0000014d/%0d", res, lat, N + 2);
        end
        count_dones(N + 6, n);
        tests_run++;
        if (n != 0) begin tests_failed++; $display("FAIL start_not_queued extra_dones=%0d want 0", n); end
    endtask

    task automatic test_kill();
        int           lat, n, hits;
        logic [N-1:0] res;
        logic         both, rdy, dn;
        issue(3'd0, 32'd5, 32'd6);
        wait_done(lat, res, both, rdy, dn);
        tests_run++;
        if (res !== 32'd30) begin tests_failed++; $display("FAIL kill_prior got %h want 1e", res); end

        // kill sampled on the edge ending cycle 10 of a DIV
        issue(3'd4, 32'd1234567, 32'd89);
        hits = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) hits++;
        end
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b1 || done !== 1'b0 || hits != 0) begin
            tests_failed++; $display("FAIL kill_calc_ready ready=%b done=%b early_dones=%0d want 1/0/0", ready, done, hits);
        end
        count_dones(N + 6, n);
        tests_run++;
        if (n != 0 || result !== 32'd30) begin
            tests_failed++; $display("FAIL kill_calc_quiet dones=%0d result=%h want 0/1e", n, result);
        end

        issue(3'd0, 32'd3, 32'd4);
        wait_done(lat, res, both, rdy, dn);
        tests_run++;
        if (res !== 32'd12 || lat != N + 2 || rdy !== 1'b1) begin
            tests_failed++; $display("FAIL kill_then_mul result=%h lat=%0d ready_next=%b want c/%0d/1", res, lat, rdy, N + 2);
        end

        // kill sampled while the sign fix-up is pending
        issue(3'd3, 32'hFFFF_FFFF, 32'h1234_5678);
        hits = 0;
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            if (done) hits++;
        end
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        count_dones(N, n);
        tests_run++;
        if (n + hits != 0 || result !== 32'd12 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL kill_fix dones=%0d result=%h ready=%b want 0/c/1", n + hits, result, ready);
        end

        // kill and start together in IDLE: request dropped
        start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0; kill = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL kill_start_ready got %b want 1", ready); end
        count_dones(N + 6, n);
        tests_run++;
        if (n != 0 || result !== 32'd12) begin
            tests_failed++; $display("FAIL kill_start_dropped dones=%0d result=%h want 0/c", n, result);
        end
    endtask

    task automatic test_reset_mid();
        int           lat, n, bad;
        logic [N-1:0] res;
        logic         both, rdy, dn;
        issue(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        bad = 0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (done || ready) bad++;
            if (k == 5) begin start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; end
            if (k == 6) start = 1'b0;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL rst_mid_busy bad_cycles=%0d want 0", bad); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        tests_run++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== '0) begin
            tests_failed++; $display("FAIL rst_mid_outputs ready=%b done=%b result=%h want 1/0/0", ready, done, result);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        count_dones(N + 6, n);
        tests_run++;
        if (n != 0) begin tests_failed++; $display("FAIL rst_mid_no_done dones=%0d want 0", n); end
        issue(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        wait_done(lat, res, both, rdy, dn);
        tests_run++;
        if (res !== model(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D) || lat != N + 2) begin
            tests_failed++; $display("FAIL rst_mid_after result=%h lat=%0d want %h/%0d",
                                     res, lat, model(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D), N + 2);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_ignored();
        test_kill();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
